// File: rtl/fireball_launcher.sv
// Fireball launch/flight/explosion sequencer: launches from the player's right edge,
// advances one step per frame, scores hits and paces explosion and cooldown by frame ticks.
//   state    | meaning
//   IDLE     | no fireball; coordinates parked at 0, waiting for a fire rising edge
//   FLY      | fireball moving right; coordinates valid for collision/draw
//   EXPLODE  | hit confirmed; coordinates frozen for explode_frames ticks
//   COOLDOWN | rearm delay of cooldown_frames ticks before the next launch
module fireball_launcher #(
    parameter int fireball_width  = 64,
    parameter int player_width    = 128,
    parameter int screen_width    = 640,
    parameter int fireball_speed  = 4,
    parameter int explode_frames  = 16,
    parameter int cooldown_frames = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       fire,
    input  logic [9:0] player_h_coord,
    input  logic [9:0] player_v_coord,
    input  logic       alian_is_dead,
    output logic [9:0] fireball_h_coord,
    output logic [9:0] fireball_v_coord,
    output logic       fireball_active,
    output logic       exploding,
    output logic       alian_kill,
    output logic [7:0] score
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLY      = 2'd1,
        ST_EXPLODE  = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_fire_d;
    logic [15:0] r_frame_cnt;
    logic [9:0]  r_h;
    logic [9:0]  r_v;
    logic        r_active;
    logic        r_exploding;
    logic        r_kill;
    logic [7:0]  r_score;

    logic        w_launch;
    logic [10:0] w_fly_right;
    logic        w_off_screen;
    logic        w_explode_done;
    logic        w_cool_done;

    assign w_launch     = fire & ~r_fire_d;
    // Right edge after the next step, kept in 11 bits so it cannot wrap past the screen.
    assign w_fly_right  = {1'b0, r_h} + 11'(fireball_speed) + 11'(fireball_width);
    assign w_off_screen = (w_fly_right > 11'(screen_width));

    // A zero-frame phase exits on the cycle right after entry.
    assign w_explode_done = (explode_frames == 0) ||
                            (frame_tick && (r_frame_cnt == 16'(explode_frames - 1)));
    assign w_cool_done    = (cooldown_frames == 0) ||
                            (frame_tick && (r_frame_cnt == 16'(cooldown_frames - 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_fire_d    <= 1'b0;
            r_frame_cnt <= '0;
            r_h         <= '0;
            r_v         <= '0;
            r_active    <= 1'b0;
            r_exploding <= 1'b0;
            r_kill      <= 1'b0;
            r_score     <= '0;
        end else begin
            r_fire_d <= fire;
            r_kill   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_state     <= ST_FLY;
                        r_active    <= 1'b1;
                        r_h         <= player_h_coord + 10'(player_width);
                        r_v         <= player_v_coord;
                        r_frame_cnt <= '0;
                    end
                end
                ST_FLY: begin
                    // A hit outranks both the frame step and the off-screen exit.
                    if (alian_is_dead) begin
                        r_state     <= ST_EXPLODE;
                        r_active    <= 1'b0;
                        r_exploding <= 1'b1;
                        r_kill      <= 1'b1;
                        r_frame_cnt <= '0;
                        if (r_score != 8'hFF)
                            r_score <= r_score + 8'd1;
                    end else if (frame_tick) begin
                        if (w_off_screen) begin
                            r_state     <= ST_COOLDOWN;
                            r_active    <= 1'b0;
                            r_frame_cnt <= '0;
                        end else begin
                            r_h <= r_h + 10'(fireball_speed);
                        end
                    end
                end
                ST_EXPLODE: begin
                    if (w_explode_done) begin
                        r_state     <= ST_COOLDOWN;
                        r_exploding <= 1'b0;
                        r_frame_cnt <= '0;
                    end else if (frame_tick) begin
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
                end
                ST_COOLDOWN: begin
                    if (w_cool_done) begin
                        r_state     <= ST_IDLE;
                        r_h         <= '0;
                        r_v         <= '0;
                        r_frame_cnt <= '0;
                    end else if (frame_tick) begin
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_active    <= 1'b0;
                    r_exploding <= 1'b0;
                    r_h         <= '0;
                    r_v         <= '0;
                    r_frame_cnt <= '0;
                end
            endcase
        end
    end

    assign fireball_h_coord = r_h;
    assign fireball_v_coord = r_v;
    assign fireball_active  = r_active;
    assign exploding        = r_exploding;
    assign alian_kill       = r_kill;
    assign score            = r_score;

endmodule

// File: doc/fireball_launcher.md
FIREBALL_LAUNCHER -- requirements
Module: fireball_launcher

Interface
REQ-001 Parameter: fireball_width, 64, fireball horizontal size in pixels.
REQ-002 Parameter: player_width, 128, player sprite width; the launch offset.
REQ-003 Parameter: screen_width, 640, visible horizontal pixels.
REQ-004 Parameter: fireball_speed, 4, pixels advanced per frame tick.
REQ-005 Parameter: explode_frames, 16, frame ticks spent in EXPLODE.
REQ-006 Parameter: cooldown_frames, 8, frame ticks spent in COOLDOWN.
REQ-007 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-008 Port: rst  input  1  synchronous active-high reset.
REQ-009 Port: frame_tick  input  1  one-cycle pulse per video frame.
REQ-010 Port: fire  input  1  fire button level, already debounced and synchronous to clk.
REQ-011 Port: player_h_coord  input  10  player top-left horizontal coordinate.
REQ-012 Port: player_v_coord  input  10  player top-left vertical coordinate.
REQ-013 Port: alian_is_dead  input  1  combinational overlap flag from the collision checker, computed from this block's fireball coordinates.
REQ-014 Port: fireball_h_coord  output  10  fireball top-left horizontal coordinate (registered).
REQ-015 Port: fireball_v_coord  output  10  fireball top-left vertical coordinate (registered).
REQ-016 Port: fireball_active  output  1  high only in FLY; the collision and draw logic ignore coordinates when low.
REQ-017 Port: exploding  output  1  high only in EXPLODE.
REQ-018 Port: alian_kill  output  1  one-cycle pulse per confirmed hit.
REQ-019 Port: score  output  8  count of hits.

Function
REQ-020 The FSM SHALL have four states: IDLE, FLY, EXPLODE, COOLDOWN.
REQ-021 A launch event SHALL be a fire rising edge, detected against a registered copy of fire; edges outside IDLE SHALL be discarded and not queued.
REQ-022 IDLE + launch event -> FLY next cycle; fireball_h_coord = player_h_coord + player_width (10-bit, wraps) and fireball_v_coord = player_v_coord, both sampled in the launch cycle.
REQ-023 FLY + frame_tick + no hit: if fireball_h_coord + fireball_speed + fireball_width > screen_width (11-bit compare), the block SHALL go to COOLDOWN with no alian_kill; otherwise fireball_h_coord SHALL increase by fireball_speed.
REQ-024 fireball_v_coord SHALL stay constant for the whole flight.
REQ-025 FLY + alian_is_dead = 1 on any cycle SHALL produce a hit: alian_kill high for exactly the next cycle, score +1 saturating at 255, transition to EXPLODE, coordinates frozen.
REQ-026 Hit and frame_tick in the same cycle: the hit SHALL win and the position SHALL NOT advance.
REQ-027 Hit and off-screen exit in the same cycle: the hit SHALL win.
REQ-028 alian_is_dead SHALL be ignored outside FLY.
REQ-029 EXPLODE SHALL last exactly explode_frames frame_tick pulses (frame counter counts ticks; exit on the cycle after the explode_frames-th tick), then go to COOLDOWN; coordinates are held.
REQ-030 COOLDOWN SHALL last exactly cooldown_frames frame_tick pulses, then go to IDLE.
REQ-031 In IDLE, fireball_h_coord and fireball_v_coord SHALL be 0.
REQ-032 The frame counter SHALL be cleared on every state entry.
REQ-033 Parameters of 0 frames SHALL make the state exit on the next cycle.

Reset
REQ-034 rst = 1 on a clock edge SHALL force: IDLE, coordinates 0, fireball_active 0, exploding 0, alian_kill 0, score 0, frame counter 0, fire history register 0.
REQ-035 Reset SHALL take priority over every event, including a hit in the same cycle; no alian_kill pulse SHALL follow.
REQ-036 If fire is held high through reset release, that SHALL count as a launch event on the first cycle after release.

Verification
REQ-037 Launch: player_h = 100, player_v = 200, fire rises -> next cycle FLY, h = 228, v = 200; after 3 ticks h = 240.
REQ-038 Miss: launch at player_h = 400 (h = 528) -> ticks advance to h = 576; next tick -> COOLDOWN, no alian_kill, score unchanged; after 8 ticks -> IDLE, h = v = 0.
REQ-039 Hit: alian_is_dead = 1 during FLY, coincident with frame_tick -> alian_kill one cycle, score 0 -> 1, h unchanged; after 16 ticks exploding drops; after 8 more ticks -> IDLE.
REQ-040 Ignored fire: fire toggled during FLY, EXPLODE, and COOLDOWN -> no relaunch; fire must rise again in IDLE.
REQ-041 Saturation: 256 hits -> score holds at 255, with alian_kill still pulsing each hit.
REQ-042 Reset mid-flight: rst is asserted in FLY with alian_is_dead = 1 -> IDLE, score 0, no alian_kill pulse.
